cam_to_world: RTL

- Inverse of the world-to-camera projection stage. Takes a camera-space point Q = (q_x, q_y, q_z) and the camera basis u, v, n with camera position C.
- Reconstructs the world-space point P = C + q_x·u + q_y·v + q_z·n. Used for picking and unprojection feedback into scene logic.
- A single shared signed multiplier is time-multiplexed by a small FSM, with valid/ready handshakes on both sides.

---
 rtl/gfx_pkg.sv | 16 +
 rtl/cam_to_world_if.sv | 24 ++
 rtl/signed_saturate.sv | 25 ++
 rtl/cam_to_world.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and width helpers for the camera/world transform stages.
package gfx_pkg;

  typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_e;

  localparam int CNT_W     = 4;
  localparam int LAST_TERM = 8;

  // Three full-precision Q*V products summed without overflow.
  function automatic int acc_width(input int q_w, input int v_w);
    return q_w + v_w + 2;
  endfunction

  localparam int ACC_WIDTH = acc_width(23, 16);

endpackage

// File: rtl/cam_to_world_if.sv
// Input/output handshake bundle for cam_to_world.
interface cam_to_world_if #(
  parameter int Q_WIDTH   = 23,
  parameter int C_WIDTH   = 18,
  parameter int V_WIDTH   = 16,
  parameter int OUT_WIDTH = 20
);
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0][Q_WIDTH-1:0]     Q;
  logic [2:0][C_WIDTH-1:0]     C;
  logic [2:0][V_WIDTH-1:0]     u;
  logic [2:0][V_WIDTH-1:0]     v;
  logic [2:0][V_WIDTH-1:0]     n;
  logic                        out_valid;
  logic                        out_ready;
  logic [2:0][OUT_WIDTH-1:0]   P;
  logic                        ovf;

  modport master (output in_valid, Q, C, u, v, n, out_ready,
                  input  in_ready, out_valid, P, ovf);
  modport slave  (input  in_valid, Q, C, u, v, n, out_ready,
                  output in_ready, out_valid, P, ovf);
endinterface

// File: rtl/signed_saturate.sv
// Clamps a wide signed value into OUT_WIDTH bits and flags when clamping occurred.
module signed_saturate #(
  parameter int IN_WIDTH  = 42,
  parameter int OUT_WIDTH = 20
) (
  input  logic signed [IN_WIDTH-1:0] din,
  output logic [OUT_WIDTH-1:0]       dout,
  output logic                       sat
);
  localparam logic signed [IN_WIDTH-1:0] MAX_V =
    {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH-1:0] MIN_V = ~MAX_V;

  always_comb begin
    sat = 1'b1;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_WIDTH-1:0];
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_WIDTH-1:0];
    end else begin
      dout = din[OUT_WIDTH-1:0];
      sat  = 1'b0;
    end
  end
endmodule

// File: rtl/cam_to_world.sv
// Reconstructs world point P = C + qx*u + qy*v + qz*n with one shared multiplier
// stepped over nine cycles (axis outer, term inner).
module cam_to_world
  import gfx_pkg::*;
#(
  parameter int C_WIDTH   = 18,
  parameter int V_WIDTH   = 16,
  parameter int FRAC_BITS = 14,
  parameter int Q_WIDTH   = 23,
  parameter int OUT_WIDTH = 20
) (
  input  logic          clk,
  input  logic          rst,
  cam_to_world_if.slave bus
);
  localparam int ACC_W  = acc_width(Q_WIDTH, V_WIDTH);
  localparam int PROD_W = Q_WIDTH + V_WIDTH;
  localparam int SUM_W  = ACC_W + 1;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0][Q_WIDTH-1:0]    q_q, q_d;
  logic [2:0][C_WIDTH-1:0]    c_q, c_d;
  logic [2:0][V_WIDTH-1:0]    u_q, u_d, v_q, v_d, n_q, n_d;
  logic signed [ACC_W-1:0]    acc_q [3];
  logic signed [ACC_W-1:0]    acc_d [3];
  logic [2:0][OUT_WIDTH-1:0]  p_q, p_d, p_sat;
  logic [2:0]                 sat_flag;
  logic                       ovf_q, ovf_d, out_valid_q, out_valid_d;

  logic [1:0]                 k, j;
  logic signed [Q_WIDTH-1:0]  mul_a;
  logic signed [V_WIDTH-1:0]  mul_b;
  logic signed [PROD_W-1:0]   prod;
  logic signed [SUM_W-1:0]    sum [3];

  always_comb begin
    case (cnt_q)
      4'd0:    {k, j} = 4'b00_00;
      4'd1:    {k, j} = 4'b00_01;
      4'd2:    {k, j} = 4'b00_10;
      4'd3:    {k, j} = 4'b01_00;
      4'd4:    {k, j} = 4'b01_01;
      4'd5:    {k, j} = 4'b01_10;
      4'd6:    {k, j} = 4'b10_00;
      4'd7:    {k, j} = 4'b10_01;
      4'd8:    {k, j} = 4'b10_10;
      default: {k, j} = 4'b00_00;
    endcase
  end

  always_comb begin
    case (j)
      2'd0:    begin mul_a = q_q[0]; mul_b = u_q[k]; end
      2'd1:    begin mul_a = q_q[1]; mul_b = v_q[k]; end
      default: begin mul_a = q_q[2]; mul_b = n_q[k]; end
    endcase
    prod = PROD_W'(mul_a) * PROD_W'(mul_b);
  end

  // Floor shift of the full-precision sum, then add C before clamping.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sum[i] = (SUM_W'(acc_q[i]) >>> FRAC_BITS) + SUM_W'($signed(c_q[i]));
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sat
    signed_saturate #(.IN_WIDTH(SUM_W), .OUT_WIDTH(OUT_WIDTH)) u_sat (
      .din  (sum[g]),
      .dout (p_sat[g]),
      .sat  (sat_flag[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    c_d         = c_q;
    u_d         = u_q;
    v_d         = v_q;
    n_d         = n_q;
    acc_d       = acc_q;
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        q_d     = bus.Q;
        c_d     = bus.C;
        u_d     = bus.u;
        v_d     = bus.v;
        n_d     = bus.n;
        acc_d   = '{default: '0};
        cnt_d   = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d[k] = acc_q[k] + ACC_W'(prod);
        if (cnt_q == CNT_W'(LAST_TERM)) state_d = FIN;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      FIN: begin
        p_d         = p_sat;
        ovf_d       = |sat_flag;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      c_q         <= '0;
      u_q         <= '0;
      v_q         <= '0;
      n_q         <= '0;
      acc_q       <= '{default: '0};
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      c_q         <= c_d;
      u_q         <= u_d;
      v_q         <= v_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.P         = p_q;
  assign bus.ovf       = ovf_q;
endmodule
